// File: rtl/subdiv_sequencer_if.sv
// Stage-side bus of the subdivision sequencer: per-stage start/busy
// handshake, per-stage RAM requests and the single shared neighbor-RAM port.
//
// Handshake: the sequencer pulses stage_start[k] for exactly one cycle. Stage
// k answers by raising stage_busy[k] within BUSY_TIMEOUT cycles and holds it
// until its work is finished. The falling edge of busy means "done". Busy of
// any stage other than the current one is ignored.
interface subdiv_sequencer_if #(
   parameter int NUM_STAGES = 3,
   parameter int ADDR_WIDTH = 11
);
   logic [NUM_STAGES-1:0]            stage_busy;
   logic [NUM_STAGES-1:0]            stage_start;
   logic [NUM_STAGES-1:0]            stage_ram_en;
   logic [NUM_STAGES*ADDR_WIDTH-1:0] stage_ram_a;
   logic [NUM_STAGES*4-1:0]          stage_ram_we;
   logic [NUM_STAGES*32-1:0]         stage_ram_di;
   logic                             RAM_NBR_EN;
   logic [ADDR_WIDTH-1:0]            RAM_NBR_A;
   logic [3:0]                       RAM_NBR_WE;
   logic [31:0]                      RAM_NBR_Di;

   modport master (
      input  stage_busy, stage_ram_en, stage_ram_a, stage_ram_we, stage_ram_di,
      output stage_start, RAM_NBR_EN, RAM_NBR_A, RAM_NBR_WE, RAM_NBR_Di
   );

   modport slave (
      output stage_busy, stage_ram_en, stage_ram_a, stage_ram_we, stage_ram_di,
      input  stage_start, RAM_NBR_EN, RAM_NBR_A, RAM_NBR_WE, RAM_NBR_Di
   );
endinterface

// File: rtl/subdiv_sequencer.sv
// Top-level scheduler of the subdivision pipeline. Launches the stages in
// order once per pass, supervises each stage's start/busy handshake and
// hands the shared neighbor-RAM port to the stage currently being run.
// All state changes on the falling clock edge, like the stages themselves.
module subdiv_sequencer #(
   parameter int NUM_STAGES   = 3,
   parameter int ADDR_WIDTH   = 11,
   parameter int BUSY_TIMEOUT = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] pass_count,
   subdiv_sequencer_if.master bus,
   output logic       busy,
   output logic       done,
   output logic       error,
   output logic [3:0] pass_idx,
   output logic [1:0] stage_idx,
   output logic [2:0] state_dbg
);

   localparam int TW = $clog2(BUSY_TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LAUNCH, S_WAIT_BUSY, S_RUN, S_NEXT, S_DONE
   } state_t;

   state_t                state_q, state_d;
   logic [NUM_STAGES-1:0] stage_start_q, stage_start_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  error_q, error_d;
   logic [3:0]            pass_idx_q, pass_idx_d;
   logic [3:0]            pass_cnt_q, pass_cnt_d;
   logic [1:0]            stage_idx_q, stage_idx_d;
   logic [TW-1:0]         timer_q, timer_d;

   logic                  cur_busy;
   logic                  last_stage;
   logic                  more_passes;
   logic [TW-1:0]         timer_inc;

   assign cur_busy    = bus.stage_busy[stage_idx_q];
   assign last_stage  = (stage_idx_q == 2'(NUM_STAGES - 1));
   // pass_count is latched at start so a changing input cannot stretch a run.
   assign more_passes = (({1'b0, pass_idx_q} + 5'd1) < {1'b0, pass_cnt_q});
   assign timer_inc   = (timer_q == TW'(BUSY_TIMEOUT)) ? timer_q : timer_q + 1'b1;

   // Next-state and next-output logic of the run sequencer.
   always_comb begin
      state_d       = state_q;
      stage_start_d = '0;
      busy_d        = busy_q;
      done_d        = 1'b0;
      error_d       = error_q;
      pass_idx_d    = pass_idx_q;
      pass_cnt_d    = pass_cnt_q;
      stage_idx_d   = stage_idx_q;
      timer_d       = timer_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               error_d = 1'b0;
               if (pass_count == 4'd0) begin
                  done_d  = 1'b1;
                  state_d = S_DONE;
               end else begin
                  busy_d      = 1'b1;
                  pass_idx_d  = '0;
                  stage_idx_d = '0;
                  pass_cnt_d  = pass_count;
                  state_d     = S_LAUNCH;
               end
            end
         end
         S_LAUNCH: begin
            stage_start_d = NUM_STAGES'(1) << stage_idx_q;
            timer_d       = '0;
            state_d       = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            timer_d = timer_inc;
            if (cur_busy) begin
               state_d = S_RUN;
            end else if (timer_inc == TW'(BUSY_TIMEOUT)) begin
               // Stage never acknowledged: abort the whole run.
               error_d = 1'b1;
               done_d  = 1'b1;
               state_d = S_DONE;
            end
         end
         S_RUN: begin
            if (!cur_busy) state_d = S_NEXT;
         end
         S_NEXT: begin
            if (!last_stage) begin
               stage_idx_d = stage_idx_q + 2'd1;
               state_d     = S_LAUNCH;
            end else if (more_passes) begin
               stage_idx_d = '0;
               pass_idx_d  = pass_idx_q + 4'd1;
               state_d     = S_LAUNCH;
            end else begin
               done_d  = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Sequencer state and registered outputs, reset asynchronously.
   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         stage_start_q <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         error_q       <= 1'b0;
         pass_idx_q    <= '0;
         pass_cnt_q    <= '0;
         stage_idx_q   <= '0;
         timer_q       <= '0;
      end else begin
         state_q       <= state_d;
         stage_start_q <= stage_start_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         error_q       <= error_d;
         pass_idx_q    <= pass_idx_d;
         pass_cnt_q    <= pass_cnt_d;
         stage_idx_q   <= stage_idx_d;
         timer_q       <= timer_d;
      end
   end

   // Shared RAM port follows the current stage only while it owns the slot.
   always_comb begin
      bus.RAM_NBR_EN = 1'b0;
      bus.RAM_NBR_A  = '0;
      bus.RAM_NBR_WE = '0;
      bus.RAM_NBR_Di = '0;
      if (state_q == S_LAUNCH || state_q == S_WAIT_BUSY || state_q == S_RUN) begin
         bus.RAM_NBR_EN = bus.stage_ram_en[stage_idx_q];
         bus.RAM_NBR_A  = bus.stage_ram_a[stage_idx_q*ADDR_WIDTH +: ADDR_WIDTH];
         bus.RAM_NBR_WE = bus.stage_ram_we[stage_idx_q*4 +: 4];
         bus.RAM_NBR_Di = bus.stage_ram_di[stage_idx_q*32 +: 32];
      end
   end

   assign bus.stage_start = stage_start_q;
   assign busy            = busy_q;
   assign done            = done_q;
   assign error           = error_q;
   assign pass_idx        = pass_idx_q;
   assign stage_idx       = stage_idx_q;
   assign state_dbg       = state_q;

endmodule

// File: tb/tb_subdiv_sequencer.sv
// Bench for subdiv_sequencer: behavioural stage models with per-launch
// delay/duration plans, a scoreboard of expected (pass, stage) launches and
// a shared-RAM ownership check. The DUT acts on negedge; the bench acts on posedge.
module tb_subdiv_sequencer;
   localparam int NS    = 3;
   localparam int AW    = 11;
   localparam int TO    = 4;
   localparam int NEVER = 255;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [3:0] pass_count;
   logic       busy, done, error;
   logic [3:0] pass_idx;
   logic [1:0] stage_idx;
   logic [2:0] state_dbg;

   subdiv_sequencer_if #(.NUM_STAGES(NS), .ADDR_WIDTH(AW)) sif ();

   subdiv_sequencer #(.NUM_STAGES(NS), .ADDR_WIDTH(AW), .BUSY_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .start(start), .pass_count(pass_count), .bus(sif),
      .busy(busy), .done(done), .error(error), .pass_idx(pass_idx),
      .stage_idx(stage_idx), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] idx_of(input logic [NS-1:0] v);
      idx_of = 2'd0;
      for (int k = 0; k < NS; k++) if (v[k]) idx_of = 2'(k);
   endfunction

   // Scoreboard of expected launches, {pass[3:0], stage[1:0]}.
   logic [5:0] exp_q[$];
   int         done_seen;

   // Per-launch stage behaviour: cycles before busy rises, cycles busy is held.
   int plan_dly [0:15];
   int plan_dur [0:15];
   int launch_n;
   logic [NS-1:0] hold_mask;
   logic          fixed_ram;
   time           launch_t, fall_t;

   // Launch monitor: every start pulse must be the next expected one.
   initial begin
      logic [5:0] e;
      done_seen = 0;
      forever begin
         @(posedge clk);
         if (!rst && sif.stage_start != '0) begin
            chk("start_onehot", 64'($onehot(sif.stage_start)), 64'd1);
            if (exp_q.size() == 0) begin
               chk("start_unexpected", 64'(sif.stage_start), 64'd0);
            end else begin
               e = exp_q.pop_front();
               chk("start_order", {pass_idx, idx_of(sif.stage_start)}, 64'(e));
            end
         end
         if (done) done_seen++;
      end
   end

   // Stage models plus the check that the shared port belongs to the current stage.
   initial begin
      int phase, cur, dly, left;
      logic [NS-1:0] model_busy;
      phase = 0; cur = 0; dly = 0; left = 0; model_busy = '0;
      sif.stage_busy = '0;
      forever begin
         @(posedge clk);
         if (rst) begin
            phase = 0;
            model_busy = '0;
         end else begin
            if (phase != 0)
               chk("ram_mux", {sif.RAM_NBR_EN, sif.RAM_NBR_A, sif.RAM_NBR_WE, sif.RAM_NBR_Di},
                   {sif.stage_ram_en[cur], sif.stage_ram_a[cur*AW +: AW],
                    sif.stage_ram_we[cur*4 +: 4], sif.stage_ram_di[cur*32 +: 32]});
            if (phase == 1) begin
               if (dly == 0) begin
                  model_busy[cur] = 1'b1;
                  phase = 2;
               end else dly--;
            end else if (phase == 2) begin
               left--;
               if (left == 0) begin
                  model_busy[cur] = 1'b0;
                  phase  = 0;
                  fall_t = $time;
               end
            end
            if (sif.stage_start != '0) begin
               cur      = int'(idx_of(sif.stage_start));
               launch_t = $time;
               dly      = plan_dly[launch_n];
               left     = plan_dur[launch_n];
               launch_n++;
               phase    = (dly == NEVER) ? 0 : 1;
            end
         end
         sif.stage_busy = model_busy | hold_mask;
      end
   end

   // Stage RAM request driver: random traffic, or fixed per-stage values.
   initial begin
      sif.stage_ram_en = '0; sif.stage_ram_a = '0; sif.stage_ram_we = '0; sif.stage_ram_di = '0;
      forever begin
         @(posedge clk);
         #2;
         if (fixed_ram) begin
            sif.stage_ram_en = 3'b111;
            sif.stage_ram_a  = {11'h155, 11'h3FF, 11'h012};
            sif.stage_ram_we = {4'h3, 4'hF, 4'hF};
            sif.stage_ram_di = {32'hCAFE0002, 32'h00000055, 32'h00000007};
         end else begin
            sif.stage_ram_en = NS'($urandom);
            for (int k = 0; k < NS; k++) begin
               sif.stage_ram_a[k*AW +: AW] = AW'($urandom);
               sif.stage_ram_we[k*4 +: 4]  = 4'($urandom);
               sif.stage_ram_di[k*32 +: 32] = $urandom;
            end
         end
      end
   end

   task automatic set_plan(input int d, input int u);
      for (int i = 0; i < 16; i++) begin
         plan_dly[i] = d;
         plan_dur[i] = u;
      end
   endtask

   task automatic chk_ram_idle(input string tag);
      chk(tag, {sif.RAM_NBR_EN, sif.RAM_NBR_A, sif.RAM_NBR_WE, sif.RAM_NBR_Di}, 64'd0);
   endtask

   // One complete run: build the expected launch list from the plan, start,
   // wait for done (bounded) and check the end-of-run outputs.
   task automatic run_case(input int pc, input bit restart, input bit hold_err);
      int   l, n;
      bit   stop, exp_err;
      logic [5:0] last;
      time  done_t;
      exp_q.delete();
      l = 0; stop = 0; exp_err = 0; last = '0;
      for (int p = 0; p < pc && !stop; p++)
         for (int s = 0; s < NS && !stop; s++) begin
            last = {4'(p), 2'(s)};
            exp_q.push_back(last);
            if (plan_dly[l] == NEVER) begin
               exp_err = 1;
               stop    = 1;
            end
            l++;
         end
      launch_n = 0;
      done_seen = 0;
      pass_count = 4'(pc);
      start = 1'b1;
      @(posedge clk);
      start = 1'b0;
      chk("busy_after_start", busy, 1);
      chk("no_start_yet", sif.stage_start, 0);
      chk("error_cleared", error, 0);
      @(posedge clk);
      chk("launch_latency", sif.stage_start, 3'b001);
      if (fixed_ram) begin
         chk("ram_a_stage0", sif.RAM_NBR_A, 11'h012);
         chk("ram_di_stage0", sif.RAM_NBR_Di, 32'd7);
         chk("ram_we_stage0", sif.RAM_NBR_WE, 4'hF);
      end
      n = 0;
      do begin
         @(posedge clk);
         n++;
         if (restart && n == 5) begin
            start = 1'b1;
            pass_count = 4'd9;
         end else if (restart && n == 6) begin
            start = 1'b0;
            pass_count = 4'(pc);
         end
         if (hold_err && sif.stage_start == 3'b010) hold_mask = 3'b101;
      end while (!done && n < 3000);
      chk("done_seen_in_time", done, 1);
      done_t = $time;
      if (exp_err) chk("timeout_latency", done_t - launch_t, 64'd40);
      else         chk("done_latency", done_t - fall_t, 64'd20);
      chk("error_flag", error, 64'(exp_err));
      chk("final_idx", {pass_idx, stage_idx}, 64'(last));
      chk("busy_during_done", busy, 1);
      chk_ram_idle("ram_idle_done");
      @(posedge clk);
      start = 1'b0;
      chk("done_width", done, 0);
      chk("busy_after_done", busy, 0);
      chk("exp_q_empty", exp_q.size(), 0);
      chk("done_count", done_seen, 1);
      chk("error_sticky", error, 64'(exp_err));
      hold_mask = '0;
      @(posedge clk);
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; pass_count = 4'd0;
      hold_mask = '0; fixed_ram = 1'b0; launch_n = 0;
      launch_t = 0; fall_t = 0;
      set_plan(0, 10);
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      chk("rst_idx", {pass_idx, stage_idx}, 0);
      chk("rst_stage_start", sif.stage_start, 0);
      chk_ram_idle("rst_ram");
      rst = 1'b0;
      @(posedge clk);

      // Single pass, stages answer one cycle after start and stay busy 10 cycles.
      fixed_ram = 1'b1;
      run_case(1, 0, 0);
      fixed_ram = 1'b0;

      // Two passes with a stray start in the middle of the run.
      set_plan(1, 4);
      run_case(2, 1, 0);

      // Stage 1 never acknowledges while the other stages' busy are stuck high.
      set_plan(0, 3);
      plan_dly[1] = NEVER;
      run_case(2, 0, 1);

      // Zero passes: done on the next cycle, nothing launched.
      exp_q.delete();
      done_seen = 0;
      pass_count = 4'd0;
      start = 1'b1;
      @(posedge clk);
      start = 1'b0;
      chk("zero_pass_done", done, 1);
      chk("zero_pass_busy", busy, 0);
      chk("zero_pass_no_start", sif.stage_start, 0);
      @(posedge clk);
      chk("zero_pass_done_width", done, 0);
      repeat (3) @(posedge clk);
      chk("zero_pass_done_count", done_seen, 1);

      // Reset asserted while stage 0 is running.
      set_plan(0, 10);
      exp_q.delete();
      exp_q.push_back(6'd0);
      launch_n = 0;
      pass_count = 4'd1;
      start = 1'b1;
      @(posedge clk);
      start = 1'b0;
      repeat (4) @(posedge clk);
      rst = 1'b1;
      #1;
      chk("rst_mid_en", sif.RAM_NBR_EN, 0);
      chk("rst_mid_we", sif.RAM_NBR_WE, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_start", sif.stage_start, 0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      rst = 1'b0;
      @(posedge clk);
      run_case(1, 0, 0);

      // Randomized runs, some with a stage that never answers.
      for (int r = 0; r < 8; r++) begin
         int pc;
         pc = $urandom_range(1, 3);
         for (int i = 0; i < 16; i++) begin
            plan_dly[i] = $urandom_range(0, 2);
            plan_dur[i] = $urandom_range(1, 6);
         end
         if (r % 4 == 3) plan_dly[$urandom_range(0, pc*NS - 1)] = NEVER;
         run_case(pc, r == 1, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
